// File: rtl/tug_player_input.sv
// tug_player_input - debounced pushbutton press pulses with an optional LFSR opponent on R.
// Optional feature macro: TUG_CPU_PLAYER_EN (R driven by the opponent instead of key_r).

module tug_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic pulse
);

  logic       sync1;
  logic       sync2;
  logic       accepted;
  logic       accepted_d;
  logic [7:0] count;
  logic       pressed;

  assign pressed = ~sync2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      accepted   <= 1'b0;
      accepted_d <= 1'b0;
      count      <= 8'd0;
      pulse      <= 1'b0;
    end else begin
      sync1      <= key;
      sync2      <= sync1;
      accepted_d <= accepted;
      pulse      <= accepted & ~accepted_d;
      // Counter tracks consecutive edges where the synchronized level disagrees
      if (pressed == accepted) begin
        count <= 8'd0;
      end else if (count == 8'(DEBOUNCE_CYCLES - 1)) begin
        accepted <= pressed;
        count    <= 8'd0;
      end else begin
        count <= count + 8'd1;
      end
    end
  end

endmodule

module tug_player_input #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TICK_CYCLES     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_l,
  input  logic       key_r,
  input  logic [2:0] difficulty,
  output logic       L,
  output logic       R
);

  tug_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
    .clk   (clk),
    .reset (reset),
    .key   (key_l),
    .pulse (L)
  );

`ifdef TUG_CPU_PLAYER_EN
  logic [9:0] lfsr;
  logic [9:0] prescale;
  logic       tick;
  logic       unused_key_r;

  assign unused_key_r = key_r;
  assign tick         = (prescale == 10'(TICK_CYCLES - 1));

  // Fibonacci LFSR for x^10 + x^7 + 1; difficulty scales the press threshold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr     <= 10'h001;
      prescale <= 10'd0;
      R        <= 1'b0;
    end else begin
      lfsr     <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
      prescale <= tick ? 10'd0 : prescale + 10'd1;
      R        <= tick && (lfsr < {difficulty, 7'b0000000});
    end
  end
`else
  logic unused_difficulty;

  assign unused_difficulty = ^difficulty;

  tug_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
    .clk   (clk),
    .reset (reset),
    .key   (key_r),
    .pulse (R)
  );
`endif

endmodule

// File: tb/tb_tug_player_input.sv
// tb_tug_player_input - directed and randomized checks of tug_player_input against a behavioural model.

module tb_tug_player_input;

  localparam int DEB  = 4;
  localparam int TICK = 8;
  localparam int HMAX = 4096;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key_l = 1'b1;
  logic       key_r = 1'b1;
  logic [2:0] difficulty = 3'd0;
  logic       L;
  logic       R;

  int errors = 0;
  int checks = 0;

  bit hist [2][HMAX];
  bit pr   [2][HMAX];
  bit acc  [2];
  bit rose [2];
  int n;
  int m_presc;
  bit stream[$];
  int pulses_l, pulses_r, l_edge, r_edge, off_tick;

  tug_player_input #(.DEBOUNCE_CYCLES(DEB), .TICK_CYCLES(TICK)) dut (
    .clk        (clk),
    .reset      (reset),
    .key_l      (key_l),
    .key_r      (key_r),
    .difficulty (difficulty),
    .L          (L),
    .R          (R)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int lfsr_value();
    int v = 0;
    for (int i = 0; i < 10; i++) v = (v << 1) | int'(stream[i]);
    return v;
  endfunction

  task automatic model_reset();
    n = 0;
    acc[0] = 0; acc[1] = 0;
    rose[0] = 0; rose[1] = 0;
    m_presc = 0;
    stream.delete();
    for (int i = 0; i < 9; i++) stream.push_back(1'b0);
    stream.push_back(1'b1);
  endtask

  // A key's accepted level flips once the last DEB synchronized samples all disagree with it
  task automatic model_key(input int id, input logic k);
    bit flip;
    hist[id][n] = k;
    pr[id][n] = (n >= 2) ? ~hist[id][n-2] : 1'b0;
    flip = 1'b1;
    for (int j = 0; j < DEB; j++) begin
      if (n - j < 0) flip = 1'b0;
      else if (pr[id][n-j] == acc[id]) flip = 1'b0;
    end
    if (flip) begin
      acc[id] = ~acc[id];
      if (acc[id]) rose[id] = 1'b1;
    end
  endtask

  task automatic edge_step();
    bit exp_l, exp_r;
    @(posedge clk);
    exp_l = rose[0];
    exp_r = rose[1];
    rose[0] = 0;
    rose[1] = 0;
    if (n < HMAX) begin
      model_key(0, key_l);
      model_key(1, key_r);
    end
`ifdef TUG_CPU_PLAYER_EN
    exp_r = (m_presc == TICK - 1) && (lfsr_value() < int'(difficulty) * 128);
    m_presc = (m_presc + 1) % TICK;
    stream.push_back(stream[0] ^ stream[3]);
    void'(stream.pop_front());
`endif
    #1;
    check("L", L, exp_l);
    check("R", R, exp_r);
    if (L === 1'b1) begin pulses_l++; l_edge = n; end
    if (R === 1'b1) begin
      pulses_r++; r_edge = n;
      if ((n % TICK) != TICK - 1) off_tick++;
    end
    n++;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic clear_counts();
    pulses_l = 0; pulses_r = 0; l_edge = -1; r_edge = -1; off_tick = 0;
  endtask

  initial begin
    model_reset();
    clear_counts();
    #1;
    check("reset_L", L, 1'b0);
    check("reset_R", R, 1'b0);
    release_reset();

    // clean press and release
    key_l = 1'b0;
    repeat (20) edge_step();
    key_l = 1'b1;
    repeat (20) edge_step();
    check("clean_pulses", pulses_l, 1);
    check("clean_edge", l_edge, 2 + DEB);

    // bounce shorter than the debounce window
    clear_counts();
    key_l = 1'b0; repeat (3) edge_step();
    key_l = 1'b1; repeat (1) edge_step();
    key_l = 1'b0; repeat (3) edge_step();
    key_l = 1'b1; repeat (12) edge_step();
    check("bounce_pulses", pulses_l, 0);

`ifndef TUG_CPU_PLAYER_EN
    clear_counts();
    key_l = 1'b0; key_r = 1'b0;
    repeat (10) edge_step();
    key_l = 1'b1; key_r = 1'b1;
    repeat (12) edge_step();
    check("simul_pulses_l", pulses_l, 1);
    check("simul_pulses_r", pulses_r, 1);
    check("simul_same_edge", l_edge, r_edge);
`endif

    // random key activity
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) key_l = ~key_l;
      if ($urandom_range(0, 3) == 0) key_r = ~key_r;
      difficulty = 3'($urandom_range(0, 7));
      edge_step();
    end

    // asynchronous reset while L is high
    key_l = 1'b1; key_r = 1'b1;
    repeat (10) edge_step();
    key_l = 1'b0;
    for (int i = 0; i < 12; i++) begin
      edge_step();
      if (L === 1'b1) break;
    end
    check("l_seen_before_reset", L, 1'b1);
    reset = 1'b0;
    #1;
    check("async_reset_L", L, 1'b0);
    check("async_reset_R", R, 1'b0);
    repeat (2) @(negedge clk);
    key_l = 1'b1;
    release_reset();
    repeat (10) edge_step();

    // key held through reset deassertion
    key_l = 1'b0;
    repeat (2) edge_step();
    reset = 1'b0;
    #1;
    check("held_reset_L", L, 1'b0);
    repeat (2) @(negedge clk);
    release_reset();
    clear_counts();
    repeat (12) edge_step();
    check("held_pulses", pulses_l, 1);
    check("held_edge", l_edge, 2 + DEB);

    // reset mid-debounce discards the press
    key_l = 1'b1;
    repeat (10) edge_step();
    key_l = 1'b0;
    repeat (4) edge_step();
    reset = 1'b0;
    #1;
    key_l = 1'b1;
    repeat (2) @(negedge clk);
    release_reset();
    clear_counts();
    repeat (15) edge_step();
    check("discard_pulses", pulses_l, 0);

`ifdef TUG_CPU_PLAYER_EN
    reset = 1'b0;
    #1;
    release_reset();
    clear_counts();
    difficulty = 3'd0;
    for (int i = 0; i < 1000; i++) begin
      key_r = 1'($urandom_range(0, 1));
      edge_step();
    end
    check("opp_d0_pulses", pulses_r, 0);
    clear_counts();
    difficulty = 3'd7;
    for (int i = 0; i < 1000; i++) begin
      key_r = 1'($urandom_range(0, 1));
      edge_step();
    end
    check("opp_d7_min_pulses", (pulses_r >= 80), 1);
    check("opp_off_tick", off_tick, 0);
    clear_counts();
    for (int i = 0; i < 300; i++) begin
      difficulty = 3'($urandom_range(0, 7));
      edge_step();
    end
    check("opp_rand_off_tick", off_tick, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tug_player_input.md
TUG_PLAYER_INPUT -- requirements
Module: tug_player_input

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive cycles a synchronized key level must differ from the accepted level before it is accepted (range 1..255).
REQ-002 SHALL have parameter TICK_CYCLES, default 8: clock cycles between opponent decision ticks (range 2..1023).
REQ-003 SHALL have port clk  input  1  sole clock; all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port key_l  input  1  raw left pushbutton, active-low, asynchronous to clk.
REQ-006 SHALL have port key_r  input  1  raw right pushbutton, active-low, asynchronous to clk.
REQ-007 SHALL have port difficulty  input  3  opponent press likelihood, 0 = never, 7 = most often.
REQ-008 SHALL have port L  output  1  registered one-cycle left-press pulse to the game.
REQ-009 SHALL have port R  output  1  registered one-cycle right-press pulse to the game.

Function
REQ-010 SHALL pass each key through a two-flop synchronizer and invert it to an active-high "pressed" level.
REQ-011 SHALL keep one debounce counter per key; the counter clears on any edge where the synchronized level equals the accepted level.
REQ-012 SHALL update the accepted level on the edge at which the synchronized level has differed for DEBOUNCE_CYCLES consecutive edges, and SHALL clear the counter on that edge.
REQ-013 SHALL drive L high for exactly one cycle, on the edge after the accepted left level rises; release edges produce no pulse.
REQ-014 SHALL produce exactly one pulse per accepted press; a held key never repeats, and a new pulse requires an accepted release followed by an accepted press.
REQ-015 Latency: with key_l first sampled low at edge t0 and held low, L SHALL be high during the cycle after edge t0+2+DEBOUNCE_CYCLES and low in every other cycle.
REQ-016 SHALL treat a glitch shorter than DEBOUNCE_CYCLES synchronized cycles as no event; the counter restarts from 0.
REQ-017 SHALL generate L and R independently; both may pulse in the same cycle, with no arbitration or priority.
REQ-018 SHALL run a 10-bit Fibonacci LFSR (taps x^10+x^7+1), seeded 10'h001, advancing every cycle; it never reaches all-zeros.
REQ-019 SHALL run a tick prescaler counting 0..TICK_CYCLES-1 and wrapping; a tick is the cycle in which the count equals TICK_CYCLES-1.
REQ-020 On a tick, the opponent SHALL press if the LFSR value is less than {difficulty, 7'b0000000}; difficulty 0 never presses.
REQ-021 SHALL sample difficulty only on tick cycles; changes between ticks take effect at the next tick.

Reset
REQ-022 While reset is low, L, R, all debounce counters, and the prescaler SHALL be 0 immediately, without waiting for clk.
REQ-023 While reset is low, synchronizer flops and accepted levels SHALL hold "released", and the LFSR SHALL hold 10'h001.
REQ-024 A key held through reset deassertion SHALL yield one pulse, per REQ-015, counted from the first edge after deassertion.
REQ-025 Reset asserted mid-debounce SHALL discard the partial count; no pulse from that press.

Configuration
REQ-026 With macro TUG_CPU_PLAYER_EN defined, R SHALL be sourced from the opponent (REQ-018..021) and key_r SHALL be ignored (its debounce logic may be removed).
REQ-027 Without TUG_CPU_PLAYER_EN, R SHALL be sourced from key_r through REQ-010..016, and the LFSR, prescaler, and difficulty input SHALL have no effect.

Verification (DEBOUNCE_CYCLES=4, TICK_CYCLES=8)
REQ-028 Clean press: key_l low at edge t0 for 20 cycles, then high for 20 cycles -> L high only in the cycle after edge t0+6; no pulse on release.
REQ-029 Bounce: key_l low 3 cycles, high 1, low 3, high -> L stays 0 throughout.
REQ-030 Simultaneous (macro off): key_l and key_r low at the same edge for 10 cycles -> L and R pulse in the same single cycle.
REQ-031 Reset: reset low 2 cycles after key_l falls -> L=0 at once; key_l held after release -> one L pulse 6 edges after deassertion.
REQ-032 Opponent (macro on): difficulty=0 for 1000 cycles -> R never high; difficulty=7 for 1000 cycles -> R pulses only on tick cycles, at least 80 pulses, key_r toggling has no effect.
